// File: rtl/button_conditioner_if.sv
// ---------------------------------------------------------------------------
// button_conditioner_if
//   Bundles the raw button pins and the conditioned button outputs that pass
//   between the board-side driver and the conditioner.
//
//   Signals (all N_BTN wide, bit0=mode, bit1=start, bit2=change):
//     btn_raw    raw asynchronous button pins (driven by master)
//     btn_level  debounced pressed level, 1 = pressed (driven by slave)
//     btn_pulse  one-cycle pulse per accepted press and per auto-repeat
//     btn_long   high while the button is held past the long-press delay
//
//   Modports:
//     master  board / testbench side: drives btn_raw, observes outputs
//     slave   conditioner side: reads btn_raw, drives outputs
// ---------------------------------------------------------------------------
interface button_conditioner_if #(
    parameter int N_BTN = 3
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_pulse;
    logic [N_BTN-1:0] btn_long;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_pulse,
        input  btn_long
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_pulse,
        output btn_long
    );
endinterface

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//   Conditions the raw push-buttons ahead of the watch FSM. Every button runs
//   through its own lane: 2-FF synchroniser, debounce, one-cycle press pulse,
//   debounced held level, long-press flag and optional auto-repeat pulses.
//   Lanes are fully independent, so simultaneous presses may produce
//   coincident pulses.
//
//   Ports:
//     clk    in   system clock
//     reset  in   asynchronous, active-low reset
//     btn    slave modport of button_conditioner_if
//              btn_raw   (in)  raw pins
//              btn_level (out) debounced pressed level
//              btn_pulse (out) press pulse + auto-repeat pulses
//              btn_long  (out) held >= REPEAT_DELAY since the accepted press
//
//   All outputs are registered; reset forces them to 0 immediately.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// button_conditioner_lane
//   One button: synchroniser + debounce/hold/repeat FSM.
//
//   Ports:
//     clk, reset   clock, async active-low reset
//     raw          raw pin for this button
//     level        debounced pressed level
//     pulse        one-cycle pulse on accepted press and every repeat
//     long_press   long-press flag
// ---------------------------------------------------------------------------
module button_conditioner_lane #(
    parameter int   DEBOUNCE_CYCLES = 1_000_000,
    parameter int   REPEAT_DELAY    = 25_000_000,
    parameter int   REPEAT_RATE     = 5_000_000,
    parameter bit   ACTIVE_LOW      = 1'b1,
    parameter bit   REPEAT_EN       = 1'b0,
    parameter int   CW              = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic pulse,
    output logic long_press
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DEB_PRESS = 3'd1,
        HELD      = 3'd2,
        REPEAT    = 3'd3,
        DEB_REL   = 3'd4
    } state_t;

    // Synchroniser resets to the released pin level so that a button still
    // held when reset lifts is seen as a fresh press.
    localparam logic IDLE_LVL = ACTIVE_LOW;

    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RR_LAST  = CW'(REPEAT_RATE - 1);

    logic [1:0]    sync_ff;
    logic          p;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          level_n, pulse_n, long_n;

    // Pressed = 1 regardless of pin polarity.
    assign p = ACTIVE_LOW ? ~sync_ff[1] : sync_ff[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_ff    <= {2{IDLE_LVL}};
            state      <= IDLE;
            cnt        <= '0;
            level      <= 1'b0;
            pulse      <= 1'b0;
            long_press <= 1'b0;
        end else begin
            sync_ff    <= {sync_ff[0], raw};
            state      <= state_n;
            cnt        <= cnt_n;
            level      <= level_n;
            pulse      <= pulse_n;
            long_press <= long_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        level_n = level;
        long_n  = long_press;
        pulse_n = 1'b0;

        case (state)
            IDLE: begin
                if (p) begin
                    state_n = DEB_PRESS;
                    cnt_n   = '0;
                end
            end

            DEB_PRESS: begin
                if (!p) begin
                    // Glitch shorter than the debounce window: drop silently.
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_n = HELD;
                    cnt_n   = '0;
                    level_n = 1'b1;
                    pulse_n = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end

            HELD: begin
                if (!p) begin
                    state_n = DEB_REL;
                    cnt_n   = '0;
                end else if (cnt == RD_LAST) begin
                    long_n = 1'b1;
                    if (REPEAT_EN) begin
                        state_n = REPEAT;
                        cnt_n   = '0;
                        pulse_n = 1'b1;
                    end else begin
                        // Non-repeating button: park the counter at the
                        // threshold so it can never wrap while held.
                        cnt_n = cnt;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end

            REPEAT: begin
                if (!p) begin
                    state_n = DEB_REL;
                    cnt_n   = '0;
                end else if (cnt == RR_LAST) begin
                    pulse_n = 1'b1;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end

            DEB_REL: begin
                if (p) begin
                    // Release bounce: back to held without a pulse; the
                    // repeat delay starts over but long_press is kept.
                    state_n = HELD;
                    cnt_n   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    level_n = 1'b0;
                    long_n  = 1'b0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end

            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end
endmodule

module button_conditioner #(
    parameter int               N_BTN           = 3,
    parameter bit               BTN_ACTIVE_LOW  = 1'b1,
    parameter int               DEBOUNCE_CYCLES = 1_000_000,
    parameter int               REPEAT_DELAY    = 25_000_000,
    parameter int               REPEAT_RATE     = 5_000_000,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = 3'b100
) (
    input  logic                 clk,
    input  logic                 reset,
    button_conditioner_if.slave  btn
);
    // Counter only ever needs to hold values up to (largest interval - 1).
    localparam int MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int CNT_MAX = (MAX_A > REPEAT_RATE) ? MAX_A : REPEAT_RATE;
    localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    logic [N_BTN-1:0] level, pulse, long_press;

    for (genvar i = 0; i < N_BTN; i++) begin : g_lane
        button_conditioner_lane #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE),
            .ACTIVE_LOW      (BTN_ACTIVE_LOW),
            .REPEAT_EN       (REPEAT_MASK[i]),
            .CW              (CW)
        ) u_lane (
            .clk        (clk),
            .reset      (reset),
            .raw        (btn.btn_raw[i]),
            .level      (level[i]),
            .pulse      (pulse[i]),
            .long_press (long_press[i])
        );
    end

    assign btn.btn_level = level;
    assign btn.btn_pulse = pulse;
    assign btn.btn_long  = long_press;
endmodule

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner
//   Directed scenarios plus randomized button activity. A behavioural model
//   describes each button in terms of run lengths of the synchronised pressed
//   level and elapsed hold time; a compare process checks all outputs against
//   it every cycle. Literal checks pin key latencies.
// ---------------------------------------------------------------------------
module tb_button_conditioner;
    localparam int           N    = 3;
    localparam int           DEB  = 4;
    localparam int           RD   = 20;
    localparam int           RR   = 5;
    localparam logic [N-1:0] MASK = 3'b100;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    button_conditioner_if #(.N_BTN(N)) bif();

    button_conditioner #(
        .N_BTN           (N),
        .BTN_ACTIVE_LOW  (1'b1),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR),
        .REPEAT_MASK     (MASK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .btn   (bif)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // p at an edge is the raw pin seen two edges earlier.
    logic [N-1:0] h1, h2;
    bit m_level[N], m_long[N], m_pulse[N], m_prevp[N];
    int run[N];   // consecutive samples with the current pressed value
    int k[N];     // edges since the hold (re)started
    int npulse[N], nfall[N];
    bit prev_lvl[N];

    task automatic model_reset();
        h1 = '1;
        h2 = '1;
        for (int i = 0; i < N; i++) begin
            m_level[i] = 0; m_long[i] = 0; m_pulse[i] = 0;
            m_prevp[i] = 0; run[i] = 0; k[i] = 0;
        end
    endtask

    task automatic model_step(input logic [N-1:0] raw);
        bit p;
        for (int i = 0; i < N; i++) begin
            p = (h2[i] == 1'b0);
            if (p == m_prevp[i]) run[i]++; else run[i] = 1;
            m_prevp[i] = p;
            m_pulse[i] = 0;
            if (!m_level[i]) begin
                if (p && run[i] == DEB + 1) begin
                    m_level[i] = 1; m_pulse[i] = 1; k[i] = 0;
                end
            end else if (!p) begin
                if (run[i] == DEB + 1) begin
                    m_level[i] = 0; m_long[i] = 0;
                end
            end else if (run[i] == 1) begin
                k[i] = 0;  // bounce during release: hold restarts
            end else begin
                k[i]++;
                if (k[i] >= RD) begin
                    m_long[i] = 1;
                    if (MASK[i] && ((k[i] - RD) % RR == 0)) m_pulse[i] = 1;
                end
            end
        end
        h2 = h1;
        h1 = raw;
    endtask

    // ---------------- compare process ----------------
    initial begin
        logic [N-1:0] el, ep, eg;
        model_reset();
        for (int i = 0; i < N; i++) begin npulse[i] = 0; nfall[i] = 0; prev_lvl[i] = 0; end
        forever begin
            @(posedge clk);
            if (!reset) model_reset(); else model_step(bif.btn_raw);
            #1;
            for (int i = 0; i < N; i++) begin
                el[i] = m_level[i]; ep[i] = m_pulse[i]; eg[i] = m_long[i];
            end
            chk("model_level", int'(bif.btn_level), int'(el));
            chk("model_pulse", int'(bif.btn_pulse), int'(ep));
            chk("model_long",  int'(bif.btn_long),  int'(eg));
            for (int i = 0; i < N; i++) begin
                if (bif.btn_pulse[i]) npulse[i]++;
                if (prev_lvl[i] && !bif.btn_level[i]) nfall[i]++;
                prev_lvl[i] = bif.btn_level[i];
            end
        end
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < N; i++) begin npulse[i] = 0; nfall[i] = 0; end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int hold_left[N];
        logic [N-1:0] r;

        // 1: reset
        reset = 1'b0;
        bif.btn_raw = 3'b111;
        #1;
        chk("reset_outputs", int'({bif.btn_level, bif.btn_pulse, bif.btn_long}), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        edges(50);
        chk("idle_after_reset", int'({bif.btn_level, bif.btn_pulse, bif.btn_long}), 0);

        // 2: single press on btn0, no repeat
        @(negedge clk);
        bif.btn_raw[0] = 1'b0;
        edges(6);
        chk("t2_no_pulse_e6", int'(bif.btn_pulse), 0);
        edges(1);
        chk("t2_pulse_e7", int'(bif.btn_pulse), 3'b001);
        chk("t2_level_e7", int'(bif.btn_level), 3'b001);
        edges(1);
        chk("t2_pulse_drop_e8", int'(bif.btn_pulse), 0);
        edges(18);
        chk("t2_long_e26", int'(bif.btn_long), 0);
        edges(1);
        chk("t2_long_e27", int'(bif.btn_long), 3'b001);
        edges(13);
        @(negedge clk);
        bif.btn_raw[0] = 1'b1;
        edges(6);
        chk("t2_level_hold_rel", int'(bif.btn_level), 3'b001);
        edges(1);
        chk("t2_level_fall", int'(bif.btn_level), 0);
        chk("t2_long_fall", int'(bif.btn_long), 0);

        // 3: short glitch on btn1
        clear_counts();
        @(negedge clk);
        bif.btn_raw[1] = 1'b0;
        repeat (3) @(negedge clk);
        bif.btn_raw[1] = 1'b1;
        edges(15);
        chk("t3_glitch_pulses", npulse[1], 0);
        chk("t3_glitch_level", int'(bif.btn_level), 0);

        // 4: bouncy press and release on btn2
        clear_counts();
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            bif.btn_raw[2] = ~bif.btn_raw[2];
        end
        @(negedge clk);
        bif.btn_raw[2] = 1'b0;
        repeat (18) @(negedge clk);
        bif.btn_raw[2] = 1'b1;
        repeat (2) @(negedge clk);
        bif.btn_raw[2] = 1'b0;
        @(negedge clk);
        bif.btn_raw[2] = 1'b1;
        repeat (2) @(negedge clk);
        bif.btn_raw[2] = 1'b0;
        @(negedge clk);
        bif.btn_raw[2] = 1'b1;
        edges(15);
        chk("t4_press_pulses", npulse[2], 1);
        chk("t4_level_falls", nfall[2], 1);

        // 5: btn2 auto-repeat with btn0 held in parallel
        clear_counts();
        @(negedge clk);
        bif.btn_raw = 3'b010;
        edges(7);
        chk("t5_press_pulses", int'(bif.btn_pulse), 3'b101);
        edges(19);
        chk("t5_long_e26", int'(bif.btn_long), 0);
        edges(1);
        chk("t5_first_repeat", int'(bif.btn_pulse), 3'b100);
        chk("t5_long_e27", int'(bif.btn_long), 3'b101);
        edges(37);
        @(negedge clk);
        bif.btn_raw = 3'b111;
        edges(12);
        chk("t5_btn2_pulses", npulse[2], 9);
        chk("t5_btn0_pulses", npulse[0], 1);

        // 6: reset while btn2 repeats
        @(negedge clk);
        bif.btn_raw[2] = 1'b0;
        edges(35);
        chk("t6_level_before", int'(bif.btn_level), 3'b100);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t6_async_drop", int'({bif.btn_level, bif.btn_pulse, bif.btn_long}), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        edges(6);
        chk("t6_no_pulse_e6", int'(bif.btn_pulse), 0);
        edges(1);
        chk("t6_repress_pulse", int'(bif.btn_pulse), 3'b100);
        edges(19);
        chk("t6_long_e26", int'(bif.btn_long), 0);
        edges(1);
        chk("t6_repeat_e27", int'(bif.btn_pulse), 3'b100);
        chk("t6_long_e27", int'(bif.btn_long), 3'b100);
        @(negedge clk);
        bif.btn_raw = 3'b111;
        edges(12);

        // Randomized activity: mixes bounce-length and hold-length intervals.
        for (int i = 0; i < N; i++) hold_left[i] = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            r = bif.btn_raw;
            for (int i = 0; i < N; i++) begin
                if (hold_left[i] == 0) begin
                    r[i] = 1'($urandom_range(0, 1));
                    hold_left[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                                               : int'($urandom_range(5, 45));
                end
                hold_left[i]--;
            end
            bif.btn_raw = r;
            if ($urandom_range(0, 699) == 0) begin
                reset = 1'b0;
                #1;
                chk("rand_async_drop", int'({bif.btn_level, bif.btn_pulse, bif.btn_long}), 0);
                repeat ($urandom_range(1, 3)) @(negedge clk);
                reset = 1'b1;
            end
        end

        @(negedge clk);
        bif.btn_raw = 3'b111;
        edges(20);
        chk("final_idle_level", int'(bif.btn_level), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
